// File: rtl/pairing_readout_ctrl_if.sv
// Handshake, core read-port and serial-line bundle for pairing_readout_ctrl.
// master = the readout sequencer, slave = the pairing core / board side.
interface pairing_readout_ctrl_if #(
  parameter int WORD_W = 304,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [3:0]        n_func;
  logic              core_run;
  logic [3:0]        core_n_func;
  logic              core_done;
  logic [ADDR_W-1:0] extout_addr;
  logic [WORD_W-1:0] extout_data;
  logic              uart_tx;
  logic              busy;
  logic              done;

  modport master (
    input  start, n_func, core_done, extout_data,
    output core_run, core_n_func, extout_addr, uart_tx, busy, done
  );

  modport slave (
    output start, n_func, core_done, extout_data,
    input  core_run, core_n_func, extout_addr, uart_tx, busy, done
  );
endinterface

// File: rtl/pairing_readout_ctrl.sv
// Runs the BN254 pairing core, then streams its result words LSB-byte-first over UART 8N1.
// Define PAIRING_READOUT_CSUM_EN to append an XOR checksum frame after each word.
module pairing_readout_ctrl #(
  parameter int WORD_W       = 304,
  parameter int ADDR_W       = 8,
  parameter int ADDR_BASE    = 0,
  parameter int NUM_WORDS    = 12,
  parameter int READ_LAT     = 3,
  parameter int CLKS_PER_BIT = 6000
) (
  input  logic clk,
  input  logic rst,
  pairing_readout_ctrl_if.master bus
);

  localparam int BYTES_PER_WORD = WORD_W / 8;
`ifdef PAIRING_READOUT_CSUM_EN
  localparam int FRAMES_PER_WORD = BYTES_PER_WORD + 1;
`else
  localparam int FRAMES_PER_WORD = BYTES_PER_WORD;
`endif
  localparam int CLK_CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BYTE_CNT_W = $clog2(FRAMES_PER_WORD + 1);
  localparam logic [ADDR_W-1:0]    BASE_ADDR  = ADDR_W'(ADDR_BASE);
  localparam logic [ADDR_W-1:0]    LAST_WORD  = ADDR_W'(NUM_WORDS - 1);
  localparam logic [CLK_CNT_W-1:0] BIT_LAST   = CLK_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]           LAT_LAST   = 4'(READ_LAT - 1);
  localparam logic [BYTE_CNT_W-1:0] FRAME_LAST = BYTE_CNT_W'(FRAMES_PER_WORD - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RUN, S_WAIT_DONE, S_LAT, S_TX_START,
    S_TX_DATA, S_TX_STOP, S_NEXT, S_DONE
  } state_t;

  state_t state, next_state;

  logic [CLK_CNT_W-1:0]  clk_cnt;
  logic [2:0]            bit_idx;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [ADDR_W-1:0]     word_cnt;
  logic [3:0]            lat_cnt;
  logic [WORD_W-1:0]     shift_buf;
  logic [ADDR_W-1:0]     addr_q;
  logic [3:0]            n_func_q;
  logic                  tx_q;
  logic                  tx_next;
  logic [7:0]            tx_byte;
  logic                  bit_end, lat_end, last_frame;
`ifdef PAIRING_READOUT_CSUM_EN
  logic [7:0]            csum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state and line-level decode; the line value is registered one cycle later.
  always_comb begin
    bit_end    = (clk_cnt == BIT_LAST);
    lat_end    = (lat_cnt == LAT_LAST);
    last_frame = (byte_cnt == FRAME_LAST);
`ifdef PAIRING_READOUT_CSUM_EN
    tx_byte = (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD)) ? csum : shift_buf[7:0];
`else
    tx_byte = shift_buf[7:0];
`endif
    next_state = state;
    tx_next    = 1'b1;
    case (state)
      S_IDLE:      if (bus.start) next_state = S_RUN;
      S_RUN:       next_state = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.core_done) next_state = S_LAT;
      S_LAT:       if (lat_end) next_state = S_TX_START;
      S_TX_START: begin
        tx_next = 1'b0;
        if (bit_end) next_state = S_TX_DATA;
      end
      S_TX_DATA: begin
        tx_next = tx_byte[bit_idx];
        if (bit_end && bit_idx == 3'd7) next_state = S_TX_STOP;
      end
      S_TX_STOP:   if (bit_end) next_state = last_frame ? S_NEXT : S_TX_START;
      S_NEXT:      next_state = (word_cnt == LAST_WORD) ? S_DONE : S_LAT;
      S_DONE:      next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Datapath: counters, read address, result buffer and the registered serial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt   <= '0;
      bit_idx   <= '0;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      lat_cnt   <= '0;
      shift_buf <= '0;
      addr_q    <= BASE_ADDR;
      n_func_q  <= '0;
      tx_q      <= 1'b1;
`ifdef PAIRING_READOUT_CSUM_EN
      csum      <= '0;
`endif
    end else begin
      tx_q <= tx_next;
      case (state)
        S_IDLE: if (bus.start) n_func_q <= bus.n_func;
        S_WAIT_DONE: if (bus.core_done) begin
          addr_q   <= BASE_ADDR;
          word_cnt <= '0;
        end
        S_LAT: begin
          if (lat_end) begin
            shift_buf <= bus.extout_data;
            byte_cnt  <= '0;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            lat_cnt   <= '0;
`ifdef PAIRING_READOUT_CSUM_EN
            csum      <= '0;
`endif
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        S_TX_START, S_TX_DATA: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + CLK_CNT_W'(1);
          if (bit_end && state == S_TX_DATA) bit_idx <= bit_idx + 3'd1;
        end
        S_TX_STOP: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + CLK_CNT_W'(1);
          if (bit_end) begin
            byte_cnt  <= byte_cnt + BYTE_CNT_W'(1);
            shift_buf <= {8'h00, shift_buf[WORD_W-1:8]};
`ifdef PAIRING_READOUT_CSUM_EN
            csum      <= csum ^ shift_buf[7:0];
`endif
          end
        end
        S_NEXT: if (word_cnt != LAST_WORD) begin
          word_cnt <= word_cnt + ADDR_W'(1);
          addr_q   <= addr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.core_run    = (state == S_RUN);
  assign bus.core_n_func = n_func_q;
  assign bus.extout_addr = addr_q;
  assign bus.uart_tx     = tx_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE);

endmodule

// File: tb/tb_pairing_readout_ctrl.sv
// Randomized self-checking bench: a UART receiver plus a byte-queue model of the expected stream.
module tb_pairing_readout_ctrl;

  localparam int WORD_W = 304;
  localparam int NUM_WORDS = 3;
  localparam int CPB = 4;
  localparam int BYTES = WORD_W / 8;
`ifdef PAIRING_READOUT_CSUM_EN
  localparam int BPW = BYTES + 1;
`else
  localparam int BPW = BYTES;
`endif
  localparam logic [7:0] BASE = 8'hFE;
  localparam logic [7:0] LAST_ADDR = 8'(BASE + 8'(NUM_WORDS - 1));

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  pairing_readout_ctrl_if #(.WORD_W(WORD_W), .ADDR_W(8)) bus_if();

  pairing_readout_ctrl #(
    .WORD_W(WORD_W), .ADDR_W(8), .ADDR_BASE(254), .NUM_WORDS(NUM_WORDS),
    .READ_LAT(3), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core read-port model: data for an address becomes valid three cycles after it is presented.
  logic [WORD_W-1:0] mem [256];
  logic [7:0] d1 = 8'h00, d2 = 8'h00;
  always @(posedge clk) begin
    d1 <= bus_if.extout_addr;
    d2 <= d1;
  end
  assign bus_if.extout_data = mem[d2];

  int check_cnt = 0;
  int fail_cnt = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  int exp_total;
  int run_cnt, done_cnt, done_cyc;
  bit rx_active = 1'b0;
  int rx_cnt, rx_idx, rx_frame_start, rx_prev_start, last_start;
  bit rx_glitch;
  logic [9:0] rx_slot;

  always @(negedge clk) begin
    if (!rst && bus_if.core_run) run_cnt++;
    if (!rst && bus_if.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Serial receiver: every bit slot must hold a constant level for exactly CPB cycles.
  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
    end else begin
      if (!rx_active && bus_if.uart_tx == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt = 0;
        rx_glitch = 1'b0;
        rx_frame_start = cyc;
      end
      if (rx_active) begin
        if (rx_cnt % CPB == 0) rx_slot[rx_cnt / CPB] = bus_if.uart_tx;
        else if (bus_if.uart_tx !== rx_slot[rx_cnt / CPB]) rx_glitch = 1'b1;
        rx_cnt++;
        if (rx_cnt == 10 * CPB) begin
          rx_active = 1'b0;
          checkOutput("frame_fmt", {61'd0, rx_glitch, rx_slot[9], rx_slot[0]}, 64'b010);
          checkOutput("byte_avail", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0)
            checkOutput($sformatf("byte%0d", rx_idx), 64'(rx_slot[8:1]), 64'(exp_q.pop_front()));
          if (rx_idx % BPW != 0)
            checkOutput("b2b_gap", 64'(rx_frame_start - rx_prev_start), 64'(10 * CPB));
          else
            checkOutput("word_addr", 64'(bus_if.extout_addr), 64'(8'(BASE + 8'(rx_idx / BPW))));
          rx_prev_start = rx_frame_start;
          last_start = rx_frame_start;
          rx_idx++;
        end
      end
    end
  end

  // mode: 0 normal, 1 core_done alongside start, 2 start while busy, 3 reset mid-frame.
  task automatic applyStimulus(input int mode, input logic [3:0] nf);
    logic [7:0] a, b, x;
    int t;
    exp_q.delete();
    for (int w = 0; w < NUM_WORDS; w++) begin
      a = 8'(BASE + 8'(w));
      x = 8'h00;
      for (int k = 0; k < BYTES; k++) begin
        b = mem[a][k*8 +: 8];
        exp_q.push_back(b);
        x = x ^ b;
      end
`ifdef PAIRING_READOUT_CSUM_EN
      exp_q.push_back(x);
`endif
    end
    exp_total = exp_q.size();
    rx_idx = 0;
    run_cnt = 0;
    done_cnt = 0;

    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.n_func = nf;
    bus_if.core_done = (mode == 1);
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.core_done = 1'b0;
    bus_if.n_func = ~nf;
    checkOutput("core_n_func", 64'(bus_if.core_n_func), 64'(nf));

    if (mode == 1) begin
      repeat (30) @(negedge clk);
      checkOutput("wait_done_hold",
                  {53'd0, bus_if.busy, bus_if.uart_tx, 1'(rx_idx == 0), bus_if.extout_addr},
                  {53'd0, 1'b1, 1'b1, 1'b1, LAST_ADDR});
    end else begin
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end
    bus_if.core_done = 1'b1;
    @(negedge clk);
    bus_if.core_done = 1'b0;

    if (mode == 2) begin
      t = 0;
      while (!(rx_idx >= 3 && rx_active && rx_cnt >= 6 && rx_cnt < 30) && t < 10000) begin
        @(negedge clk);
        t++;
      end
      checkOutput("busy_window", 64'(t < 10000), 64'd1);
      bus_if.start = 1'b1;
      bus_if.n_func = 4'hA;
      @(negedge clk);
      bus_if.start = 1'b0;
    end

    if (mode == 3) begin
      t = 0;
      while (!(rx_idx == 4 && rx_active && rx_cnt >= 8 && rx_cnt < 30) && t < 10000) begin
        @(negedge clk);
        t++;
      end
      checkOutput("rst_window", 64'(t < 10000), 64'd1);
      #1 rst = 1'b1;
      #1 checkOutput("async_rst",
                     {53'd0, bus_if.uart_tx, bus_if.busy, bus_if.core_run, bus_if.extout_addr},
                     {53'd0, 1'b1, 1'b0, 1'b0, BASE});
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      checkOutput("rst_run_cnt", 64'(run_cnt), 64'd1);
      repeat (5) @(negedge clk);
      return;
    end

    t = 0;
    while (done_cnt == 0 && t < 12000) begin
      @(negedge clk);
      t++;
    end
    checkOutput("done_seen", 64'(done_cnt > 0), 64'd1);
    repeat (50) @(negedge clk);
    checkOutput("run_pulses", 64'(run_cnt), 64'd1);
    checkOutput("done_pulses", 64'(done_cnt), 64'd1);
    checkOutput("byte_total", 64'(rx_idx), 64'(exp_total));
    checkOutput("done_timing", 64'(done_cyc - last_start), 64'(10 * CPB));
    checkOutput("idle_after", {62'd0, bus_if.busy, bus_if.uart_tx}, 64'b01);
    checkOutput("n_func_kept", 64'(bus_if.core_n_func), 64'(nf));
  endtask

  task automatic fillRandom();
    for (int w = 0; w < NUM_WORDS; w++)
      for (int k = 0; k < BYTES; k++)
        mem[8'(BASE + 8'(w))][k*8 +: 8] = 8'($urandom);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    bus_if.start = 1'b0;
    bus_if.n_func = 4'h0;
    bus_if.core_done = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_state",
                {49'd0, bus_if.uart_tx, bus_if.busy, bus_if.core_run, bus_if.done,
                 bus_if.core_n_func, bus_if.extout_addr},
                {49'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, BASE});
    rst = 1'b0;
    repeat (100) begin
      @(negedge clk);
      checkOutput("idle",
                  {52'd0, bus_if.uart_tx, bus_if.busy, bus_if.core_run, bus_if.done, bus_if.extout_addr},
                  {52'd0, 4'b1000, BASE});
    end

    // Counting pattern at the base word, all-0xA5 word, and a single 0x3C byte in a zero word.
    for (int k = 0; k < BYTES; k++) begin
      mem[BASE][k*8 +: 8]  = 8'(8'h26 - 8'(k));
      mem[8'hFF][k*8 +: 8] = 8'hA5;
    end
    mem[8'h00] = '0;
    mem[8'h00][$urandom_range(0, BYTES - 1)*8 +: 8] = 8'h3C;
    applyStimulus(0, 4'h5);

    fillRandom();
    applyStimulus(1, 4'($urandom));
    fillRandom();
    applyStimulus(2, 4'($urandom));
    fillRandom();
    applyStimulus(3, 4'($urandom));
    fillRandom();
    applyStimulus(0, 4'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/pairing_readout_ctrl.md
Name: pairing_readout_ctrl

Overview:
Sequencer wrapped around the BN254 pairing core. It issues the run pulse, waits for completion, then walks the core's external-output address space. Each result word is latched and serialized LSB-byte-first over a UART 8N1 transmitter. It replaces the shift-register bit-probe readout with a host-readable byte stream at the board top level.

Parameters:
WORD_W, 304, width of core extout_data; must be a multiple of 8
ADDR_W, 8, width of core extout_addr
ADDR_BASE, 0, first result address read
NUM_WORDS, 12, number of consecutive result words sent per run (1..2^ADDR_W)
READ_LAT, 3, cycles from extout_addr change to valid extout_data (1..15)
CLKS_PER_BIT, 6000, clk cycles per UART bit (>=2)

Ports:
clk  in  1  single clock; all logic rising-edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; accepted only in IDLE, ignored otherwise
n_func  in  4  function code, captured on accepted start
core_run  out  1  one-cycle run pulse to pairing core
core_n_func  out  4  registered function code to core
core_done  in  1  core completion pulse/level; sampled only in WAIT_DONE
extout_addr  out  ADDR_W  read address to core
extout_data  in  WORD_W  core read data
uart_tx  out  1  serial line, idle high
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after last stop bit of last word

Behaviour:
- Reset (async assert): state IDLE; uart_tx=1, core_run=0, core_n_func=0, extout_addr=ADDR_BASE, busy=0, done=0; all counters 0. Reset mid-frame truncates the frame, and uart_tx goes high immediately.
- IDLE: start=1 -> capture n_func into core_n_func, go RUN.
- RUN: core_run=1 for exactly this one cycle -> WAIT_DONE.
- WAIT_DONE: core_done=1 -> extout_addr=ADDR_BASE, word_cnt=0 -> LAT. No timeout.
- LAT: count READ_LAT cycles with extout_addr stable, then latch extout_data into shift buffer -> TX_START with byte_cnt=0.
- TX_START: uart_tx=0 for CLKS_PER_BIT cycles -> TX_DATA.
- TX_DATA: 8 bits of buffer[7:0], LSB first, each held CLKS_PER_BIT cycles. After bit 7 -> TX_STOP.
- TX_STOP: uart_tx=1 for CLKS_PER_BIT cycles. Then buffer >>= 8 and byte_cnt++.
  - If byte_cnt < WORD_W/8: -> TX_START (back-to-back frames, no idle gap).
  - Else -> NEXT.
- NEXT: if word_cnt == NUM_WORDS-1 -> DONE. Else word_cnt++, extout_addr++ (wraps modulo 2^ADDR_W), -> LAT.
- DONE: done=1 for one cycle -> IDLE.
- Frame timing: one byte = 10*CLKS_PER_BIT cycles. Words per run = NUM_WORDS. Bytes per word = WORD_W/8 (38 at default).
- start while busy: dropped, no queuing. core_done outside WAIT_DONE: ignored.
- start and core_done in the same cycle in IDLE: start accepted; core_done not remembered.
- uart_tx is registered (no glitches). The bit counter reloads on each bit boundary.

Optional Feature:
PAIRING_READOUT_CSUM_EN
- Defined: after the last data byte of each word, one extra frame carries the XOR of that word's WORD_W/8 bytes. Bytes per word = WORD_W/8+1.
- Undefined: no checksum frame; checksum logic is absent.

Test Plan:
- Reset idle: CLKS_PER_BIT=4; hold rst 3 cycles, then run 100 cycles with start=0 -> uart_tx=1, busy=0, core_run=0, extout_addr=ADDR_BASE throughout.
- Single word: NUM_WORDS=1, READ_LAT=3, CLKS_PER_BIT=4.
  - start with n_func=4'h5 -> core_run one pulse, core_n_func=5.
  - Model returns 304'h01_02..._26 at address 0 after core_done.
  - Required: 38 frames, first byte 0x26, last 0x01, each 40 cycles.
  - done pulses exactly 38*40 cycles after the first start bit.
- Multi-word wrap: ADDR_BASE=8'hFE, NUM_WORDS=3 -> extout_addr sequence FE, FF, 00. Each word is latched READ_LAT cycles after its address change; 114 bytes in order.
- start while busy: pulse start during TX_DATA -> no second core_run, byte stream unchanged, a single done.
- Async reset mid-frame: assert rst during a data bit of byte 5 -> uart_tx=1 within the same cycle, busy=0. A following start produces a complete fresh run.
- With PAIRING_READOUT_CSUM_EN: word of all bytes 0xA5 -> 39th frame = 0x00. Word with a single nonzero byte 0x3C -> 39th frame = 0x3C.
